// File: rtl/axi_read_arbiter.sv
// Arbitrates single-beat fetch and load reads onto one AXI4 read channel, one transaction at a time.
// Optional macro ROUND_ROBIN_EN: alternate grants when both ports wait; otherwise load has fixed priority.
module axi_read_arbiter #(
    parameter int ADDR_W = 15
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              f_req,
    input  logic [ADDR_W-1:0] f_addr,
    output logic              f_done,
    output logic [31:0]       f_data,
    input  logic              l_req,
    input  logic [ADDR_W-1:0] l_addr,
    output logic              l_done,
    output logic [31:0]       l_data,
    output logic              rd_err,
    output logic [ADDR_W-1:0] araddr,
    output logic [3:0]        arid,
    output logic              arvalid,
    input  logic              arready,
    output logic [7:0]        arlen,
    output logic [2:0]        arsize,
    output logic [1:0]        arburst,
    output logic [3:0]        arcache,
    output logic              arlock,
    output logic [2:0]        arprot,
    output logic [3:0]        arqos,
    input  logic [31:0]       rdata,
    input  logic [1:0]        rresp,
    input  logic              rvalid,
    output logic              rready
);
    typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;

    state_t            state_q, state_d;
    logic              f_pend_q, f_pend_d, l_pend_q, l_pend_d;
    logic [ADDR_W-1:0] f_addr_q, f_addr_d, l_addr_q, l_addr_d;
    logic [ADDR_W-1:0] araddr_q, araddr_d;
    logic              gnt_load_q, gnt_load_d;
    logic              arvalid_q, arvalid_d, rready_q, rready_d;
    logic              f_done_q, f_done_d, l_done_q, l_done_d, rd_err_q, rd_err_d;
    logic [31:0]       f_data_q, f_data_d, l_data_q, l_data_d;
    logic              pick_load, f_busy, l_busy;
`ifdef ROUND_ROBIN_EN
    logic              last_load_q, last_load_d;
`endif

    // A port is busy from its grant until the cycle its beat is accepted.
    assign f_busy = (state_q != IDLE) && !gnt_load_q;
    assign l_busy = (state_q != IDLE) &&  gnt_load_q;

    always_comb begin
        state_d    = state_q;
        f_pend_d   = f_pend_q;
        l_pend_d   = l_pend_q;
        f_addr_d   = f_addr_q;
        l_addr_d   = l_addr_q;
        araddr_d   = araddr_q;
        gnt_load_d = gnt_load_q;
        arvalid_d  = arvalid_q;
        rready_d   = rready_q;
        f_done_d   = 1'b0;
        l_done_d   = 1'b0;
        rd_err_d   = 1'b0;
        f_data_d   = f_data_q;
        l_data_d   = l_data_q;
`ifdef ROUND_ROBIN_EN
        last_load_d = last_load_q;
        pick_load   = l_pend_q && (!f_pend_q || !last_load_q);
`else
        pick_load   = l_pend_q;
`endif

        if (f_req && !f_pend_q && !f_busy) begin
            f_pend_d = 1'b1;
            f_addr_d = f_addr;
        end
        if (l_req && !l_pend_q && !l_busy) begin
            l_pend_d = 1'b1;
            l_addr_d = l_addr;
        end

        case (state_q)
            IDLE: begin
                if (f_pend_q || l_pend_q) begin
                    if (pick_load) begin
                        l_pend_d = 1'b0;
                        araddr_d = l_addr_q;
                    end else begin
                        f_pend_d = 1'b0;
                        araddr_d = f_addr_q;
                    end
                    gnt_load_d = pick_load;
`ifdef ROUND_ROBIN_EN
                    last_load_d = pick_load;
`endif
                    arvalid_d = 1'b1;
                    state_d   = ADDR;
                end
            end
            ADDR: begin
                if (arready) begin
                    arvalid_d = 1'b0;
                    rready_d  = 1'b1;
                    state_d   = DATA;
                end
            end
            DATA: begin
                if (rvalid) begin
                    rready_d = 1'b0;
                    rd_err_d = (rresp != 2'b00);
                    if (gnt_load_q) begin
                        l_data_d = rdata;
                        l_done_d = 1'b1;
                    end else begin
                        f_data_d = rdata;
                        f_done_d = 1'b1;
                    end
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q    <= IDLE;
            f_pend_q   <= 1'b0;
            l_pend_q   <= 1'b0;
            f_addr_q   <= '0;
            l_addr_q   <= '0;
            araddr_q   <= '0;
            gnt_load_q <= 1'b0;
            arvalid_q  <= 1'b0;
            rready_q   <= 1'b0;
            f_done_q   <= 1'b0;
            l_done_q   <= 1'b0;
            rd_err_q   <= 1'b0;
            f_data_q   <= '0;
            l_data_q   <= '0;
`ifdef ROUND_ROBIN_EN
            last_load_q <= 1'b1;
`endif
        end else begin
            state_q    <= state_d;
            f_pend_q   <= f_pend_d;
            l_pend_q   <= l_pend_d;
            f_addr_q   <= f_addr_d;
            l_addr_q   <= l_addr_d;
            araddr_q   <= araddr_d;
            gnt_load_q <= gnt_load_d;
            arvalid_q  <= arvalid_d;
            rready_q   <= rready_d;
            f_done_q   <= f_done_d;
            l_done_q   <= l_done_d;
            rd_err_q   <= rd_err_d;
            f_data_q   <= f_data_d;
            l_data_q   <= l_data_d;
`ifdef ROUND_ROBIN_EN
            last_load_q <= last_load_d;
`endif
        end
    end

    assign f_done  = f_done_q;
    assign l_done  = l_done_q;
    assign f_data  = f_data_q;
    assign l_data  = l_data_q;
    assign rd_err  = rd_err_q;
    assign araddr  = araddr_q;
    assign arid    = {3'b000, gnt_load_q};
    assign arvalid = arvalid_q;
    assign rready  = rready_q;

    // Single-beat, 4-byte, incrementing, normal non-cacheable bufferable reads.
    assign arlen   = 8'd0;
    assign arsize  = 3'b010;
    assign arburst = 2'b01;
    assign arcache = 4'b0011;
    assign arlock  = 1'b0;
    assign arprot  = 3'b000;
    assign arqos   = 4'b0000;
endmodule

// File: tb/tb_axi_read_arbiter.sv
// Bench for axi_read_arbiter: directed scenarios plus random traffic against a transaction-level model.
`timescale 1ns/1ps
module tb_axi_read_arbiter;
    localparam int AW = 15;
`ifdef ROUND_ROBIN_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rstn = 1'b0;
    logic          f_req = 1'b0, l_req = 1'b0;
    logic [AW-1:0] f_addr = '0, l_addr = '0;
    logic          f_done, l_done, rd_err;
    logic [31:0]   f_data, l_data;
    logic [AW-1:0] araddr;
    logic [3:0]    arid;
    logic          arvalid, rready;
    logic          arready = 1'b0;
    logic [31:0]   rdata = '0;
    logic [1:0]    rresp = '0;
    logic          rvalid = 1'b0;
    logic [7:0]    arlen;
    logic [2:0]    arsize;
    logic [1:0]    arburst;
    logic [3:0]    arcache;
    logic          arlock;
    logic [2:0]    arprot;
    logic [3:0]    arqos;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    axi_read_arbiter #(.ADDR_W(AW)) dut (
        .clk(clk), .rstn(rstn),
        .f_req(f_req), .f_addr(f_addr), .f_done(f_done), .f_data(f_data),
        .l_req(l_req), .l_addr(l_addr), .l_done(l_done), .l_data(l_data),
        .rd_err(rd_err), .araddr(araddr), .arid(arid), .arvalid(arvalid), .arready(arready),
        .arlen(arlen), .arsize(arsize), .arburst(arburst), .arcache(arcache),
        .arlock(arlock), .arprot(arprot), .arqos(arqos),
        .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Transaction-level model: pending requests per port, one in-flight read (m_cur, -1 = none).
    logic          m_pend [2];
    logic [AW-1:0] m_addr [2];
    int            m_cur = -1;
    logic          m_acc = 1'b0;
    logic          m_last_load = 1'b1;
    logic          cap [2];
    int            g;
    logic          e_arvalid = 0, e_rready = 0, e_fdone = 0, e_ldone = 0, e_rderr = 0;
    logic [AW-1:0] e_araddr = '0;
    logic [3:0]    e_arid = '0;
    logic [31:0]   e_fdata = '0, e_ldata = '0;

    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            m_pend[0] = 0; m_pend[1] = 0; m_addr[0] = '0; m_addr[1] = '0;
            m_cur = -1; m_acc = 0; m_last_load = 1;
            e_arvalid = 0; e_rready = 0; e_fdone = 0; e_ldone = 0; e_rderr = 0;
            e_araddr = '0; e_arid = '0; e_fdata = '0; e_ldata = '0;
        end else begin
            cap[0] = f_req && !m_pend[0] && (m_cur != 0);
            cap[1] = l_req && !m_pend[1] && (m_cur != 1);
            e_fdone = 0; e_ldone = 0; e_rderr = 0;
            if (m_cur < 0) begin
                if (m_pend[0] || m_pend[1]) begin
                    if (m_pend[0] && m_pend[1]) g = RR ? (m_last_load ? 0 : 1) : 1;
                    else g = m_pend[1] ? 1 : 0;
                    m_last_load = (g == 1);
                    m_pend[g] = 0; m_cur = g; m_acc = 0;
                    e_arvalid = 1; e_araddr = m_addr[g]; e_arid = (g == 1) ? 4'd1 : 4'd0;
                end
            end else if (!m_acc) begin
                if (arready) begin m_acc = 1; e_arvalid = 0; e_rready = 1; end
            end else if (rvalid) begin
                e_rready = 0; e_rderr = (rresp != 2'b00);
                if (m_cur == 1) begin e_ldone = 1; e_ldata = rdata; end
                else begin e_fdone = 1; e_fdata = rdata; end
                m_cur = -1;
            end
            if (cap[0]) begin m_pend[0] = 1; m_addr[0] = f_addr; end
            if (cap[1]) begin m_pend[1] = 1; m_addr[1] = l_addr; end
        end
    end

    always @(negedge clk) begin
        chk("arvalid", arvalid, e_arvalid);
        chk("rready", rready, e_rready);
        chk("araddr", araddr, e_araddr);
        chk("arid", arid, e_arid);
        chk("f_done", f_done, e_fdone);
        chk("l_done", l_done, e_ldone);
        chk("f_data", f_data, e_fdata);
        chk("l_data", l_data, e_ldata);
        if (e_fdone || e_ldone) chk("rd_err", rd_err, e_rderr);
        chk("arvalid_rready_excl", arvalid & rready, 0);
        chk("done_excl", f_done & l_done, 0);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        step();
        #1 rstn = 1'b0;
        f_req = 0; l_req = 0; arready = 0; rvalid = 0;
        step();
        step();
        rstn = 1'b1;
    endtask

    task automatic wait_done(input int maxc, input bit mirror, output int lat,
                             output logic fd, output logic ld, output logic err);
        lat = -1; fd = 0; ld = 0; err = 0;
        for (int i = 1; i <= maxc; i++) begin
            step();
            f_req = 0; l_req = 0;
            if (mirror) rdata = {16'hA5A5, 1'b0, araddr};
            if (f_done || l_done) begin
                lat = i; fd = f_done; ld = l_done; err = rd_err;
                break;
            end
        end
    endtask

    int   lat, n;
    logic fd, ld, err;
    logic seen;

    initial begin
        do_reset();
        chk("rst_arvalid", arvalid, 0);
        chk("rst_rready", rready, 0);
        chk("rst_f_data", f_data, 0);
        chk("rst_l_data", l_data, 0);
        chk("rst_araddr", araddr, 0);
        chk("const_ar", {arlen, arsize, arburst, arcache, arlock, arprot, arqos},
            {8'd0, 3'b010, 2'b01, 4'b0011, 1'b0, 3'b000, 4'b0000});

        // Single fetch on a zero-wait slave.
        arready = 1; rvalid = 1; rdata = 32'hDEADBEEF; rresp = 0;
        step();
        f_req = 1; f_addr = 15'h0040;
        seen = 0; lat = -1;
        for (int i = 1; i <= 10; i++) begin
            step();
            f_req = 0;
            if (arvalid && !seen) begin
                seen = 1;
                chk("single_araddr", araddr, 15'h0040);
                chk("single_arid", arid, 0);
            end
            if (f_done) begin lat = i; break; end
        end
        chk("single_lat", lat, 4);
        chk("single_f_data", f_data, 32'hDEADBEEF);
        chk("single_rd_err", rd_err, 0);

        // Address-channel backpressure for three cycles.
        step();
        arready = 0;
        f_req = 1; f_addr = 15'h1234;
        step(); f_req = 0;
        step();
        for (int i = 0; i < 3; i++) begin
            chk("bp_arvalid", arvalid, 1);
            chk("bp_araddr", araddr, 15'h1234);
            step();
        end
        arready = 1;
        n = 5; lat = -1;
        for (int i = 0; i < 10; i++) begin
            step(); n++;
            if (f_done) begin lat = n; break; end
        end
        chk("bp_lat", lat, 7);

        // Simultaneous requests from reset.
        do_reset();
        arready = 1; rvalid = 1; rresp = 0;
        step();
        f_req = 1; f_addr = 15'h0100; l_req = 1; l_addr = 15'h0200;
        wait_done(12, 1, lat, fd, ld, err);
        chk("sim_first_lat", lat, 4);
        chk("sim_first_is_fetch", fd, RR ? 1 : 0);
        wait_done(12, 1, lat, fd, ld, err);
        chk("sim_second_lat", lat, 3);
        chk("sim_second_is_fetch", fd, RR ? 0 : 1);
        chk("sim_f_data", f_data, 32'hA5A5_0100);
        chk("sim_l_data", l_data, 32'hA5A5_0200);

        // Four rounds of simultaneous requests.
        for (int r = 0; r < 4; r++) begin
            step();
            f_req = 1; f_addr = 15'($urandom); l_req = 1; l_addr = 15'($urandom);
            wait_done(12, 1, lat, fd, ld, err);
            chk("rr_first_fetch", fd, RR ? 1 : 0);
            wait_done(12, 1, lat, fd, ld, err);
            chk("rr_second_load", ld, RR ? 1 : 0);
        end

        // Error response on a load, then a clean fetch.
        step();
        rresp = 2'b10;
        l_req = 1; l_addr = 15'h0300;
        wait_done(12, 0, lat, fd, ld, err);
        chk("err_l_done", ld, 1);
        chk("err_rd_err", err, 1);
        rresp = 2'b00;
        step();
        f_req = 1; f_addr = 15'h0304;
        wait_done(12, 0, lat, fd, ld, err);
        chk("clean_f_done", fd, 1);
        chk("clean_rd_err", err, 0);

        // Reset while waiting for read data.
        rvalid = 0; arready = 1;
        step();
        f_req = 1; f_addr = 15'h0500;
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            step(); f_req = 0;
            if (rready) begin seen = 1; break; end
        end
        chk("rst_mid_reached_data", seen, 1);
        #2 rstn = 0;
        #1;
        chk("rst_mid_rready", rready, 0);
        chk("rst_mid_arvalid", arvalid, 0);
        step(); step();
        rstn = 1; rvalid = 1; rdata = 32'h1357_9BDF;
        n = 0;
        for (int i = 0; i < 6; i++) begin
            step();
            if (f_done || l_done || rready) n++;
        end
        chk("rst_mid_no_done", n, 0);
        f_req = 1; f_addr = 15'h0600;
        wait_done(12, 0, lat, fd, ld, err);
        chk("rst_mid_next_lat", lat, 4);
        chk("rst_mid_next_data", f_data, 32'h1357_9BDF);

        // Random traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            step();
            f_req   = ($urandom_range(0, 3) == 0);
            l_req   = ($urandom_range(0, 3) == 0);
            f_addr  = 15'($urandom);
            l_addr  = 15'($urandom);
            arready = 1'($urandom_range(0, 1));
            rvalid  = ($urandom_range(0, 2) != 0);
            rdata   = $urandom;
            rresp   = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
        end
        f_req = 0; l_req = 0; arready = 1; rvalid = 1;
        for (int i = 0; i < 20; i++) step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
